// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline definitions: stage occupancy encoding and default
// control/payload widths for each inter-stage register.
package pipe_stage_skid_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    localparam int IFID_CTRL_W  = 8;
    localparam int IFID_DATA_W  = 64;
    localparam int IDEX_CTRL_W  = 8;
    localparam int IDEX_DATA_W  = 160;
    localparam int EXMEM_CTRL_W = 8;
    localparam int EXMEM_DATA_W = 128;
    localparam int MEMWB_CTRL_W = 8;
    localparam int MEMWB_DATA_W = 96;

endpackage

// File: rtl/pipe_stage_skid_entry.sv
// One pipeline storage slot: valid flag plus control and payload, with
// load and clear. A cleared slot holds all-zero ctrl/data.
module pipe_entry #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 160
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    // Slot register, updated on the pipeline's falling edge.
    always_ff @(negedge clk) begin
        if (reset || clear) begin
            valid <= 1'b0;
            ctrl  <= {CTRL_W{1'b0}};
            data  <= {DATA_W{1'b0}};
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= in_ctrl;
            data  <= in_data;
        end else begin
            valid <= valid;
            ctrl  <= ctrl;
            data  <= data;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with optional two-entry skid buffer, flush,
// power gating and a saturating stall counter. State updates on negedge clk.
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int CTRL_W      = IDEX_CTRL_W,
    parameter int DATA_W      = IDEX_DATA_W,
    parameter int SKID        = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   power,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [DATA_W-1:0]      out_data,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    stage_state_e state_r, state_n;

    logic              main_valid, skid_valid;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_in_ctrl;
    logic [DATA_W-1:0] main_data, skid_data, main_in_data;
    logic              main_load, main_from_skid, main_clear;
    logic              skid_load, skid_clear;
    logic              accept, pop;
    logic [STALL_CNT_W-1:0] stall_cnt_r;

    // With a skid slot, in_ready depends only on registered state.
    assign in_ready = (SKID != 0) ? (power & ~skid_valid)
                                  : (power & (~main_valid | out_ready));
    assign accept   = in_valid & in_ready;
    assign pop      = main_valid & out_ready & power;

    assign main_in_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
    assign main_in_data = main_from_skid ? skid_data : in_data;

    // Occupancy state register.
    always_ff @(negedge clk) begin
        if (reset) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state and slot control; flush wins even while power is low.
    always_comb begin
        state_n        = state_r;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        main_clear     = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush) begin
            state_n    = ST_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else if (!power) begin
            state_n = state_r;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept) begin
                        state_n   = ST_ONE;
                        main_load = 1'b1;
                    end else begin
                        state_n = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        main_load = 1'b1;
                    end else if (accept && (SKID != 0)) begin
                        state_n   = ST_FULL;
                        skid_load = 1'b1;
                    end else if (pop) begin
                        state_n    = ST_EMPTY;
                        main_clear = 1'b1;
                    end else begin
                        state_n = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state_n        = ST_ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                    end else begin
                        state_n = ST_FULL;
                    end
                end
                default: begin
                    state_n    = ST_EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk     (clk),
        .reset   (reset),
        .clear   (main_clear),
        .load    (main_load),
        .in_ctrl (main_in_ctrl),
        .in_data (main_in_data),
        .valid   (main_valid),
        .ctrl    (main_ctrl),
        .data    (main_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
                .clk     (clk),
                .reset   (reset),
                .clear   (skid_clear),
                .load    (skid_load),
                .in_ctrl (in_ctrl),
                .in_data (in_data),
                .valid   (skid_valid),
                .ctrl    (skid_ctrl),
                .data    (skid_data)
            );
        end else begin : g_noskid
            assign skid_valid = 1'b0;
            assign skid_ctrl  = {CTRL_W{1'b0}};
            assign skid_data  = {DATA_W{1'b0}};
        end
    endgenerate

    // Saturating stall counter; flush leaves it alone.
    always_ff @(negedge clk) begin
        if (reset) begin
            stall_cnt_r <= {STALL_CNT_W{1'b0}};
        end else if (power && main_valid && !out_ready &&
                     (stall_cnt_r != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Main ctrl is zeroed whenever the slot is empty, so it doubles as the bubble.
    assign out_valid = main_valid;
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: three configurations driven in parallel and
// checked every cycle against a queue model, plus literal spot checks.
module tb_pipe_stage_skid;

    logic         clk = 1'b0;
    logic         reset, flush, power, in_valid, out_ready;
    logic [7:0]   in_ctrl;
    logic [159:0] in_data;

    logic         ir0, ir1, ir2, ov0, ov1, ov2;
    logic [7:0]   oc0, oc1, oc2;
    logic [159:0] od0, od1, od2;
    logic [15:0]  sc0, sc1;
    logic [3:0]   sc2;

    logic         ir[3], ov[3];
    logic [7:0]   oc[3];
    logic [159:0] od[3];
    logic [15:0]  sc[3];

    int           checks = 0;
    int           errors = 0;
    logic         chk = 1'b0;

    // Model: each stage is a FIFO of capacity cap[i].
    int           cap[3]  = '{2, 1, 2};
    int           cmax[3] = '{65535, 65535, 15};
    int           n[3]    = '{0, 0, 0};
    int           cnt[3]  = '{0, 0, 0};
    logic [7:0]   qc[3][2];
    logic [159:0] qd[3][2];

    always #5 clk = ~clk;

    pipe_stage_skid dut0 (
        .clk(clk), .reset(reset), .flush(flush), .power(power),
        .in_valid(in_valid), .in_ready(ir0), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_ctrl(oc0), .out_data(od0),
        .stall_cnt(sc0));

    pipe_stage_skid #(.SKID(0)) dut1 (
        .clk(clk), .reset(reset), .flush(flush), .power(power),
        .in_valid(in_valid), .in_ready(ir1), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_ctrl(oc1), .out_data(od1),
        .stall_cnt(sc1));

    pipe_stage_skid #(.STALL_CNT_W(4)) dut2 (
        .clk(clk), .reset(reset), .flush(flush), .power(power),
        .in_valid(in_valid), .in_ready(ir2), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov2), .out_ready(out_ready), .out_ctrl(oc2), .out_data(od2),
        .stall_cnt(sc2));

    always_comb begin
        ir[0] = ir0; ir[1] = ir1; ir[2] = ir2;
        ov[0] = ov0; ov[1] = ov1; ov[2] = ov2;
        oc[0] = oc0; oc[1] = oc1; oc[2] = oc2;
        od[0] = od0; od[1] = od1; od[2] = od2;
        sc[0] = sc0; sc[1] = sc1; sc[2] = {12'd0, sc2};
    end

    function automatic logic exp_ready(int i);
        if (cap[i] == 2) return power && (n[i] < 2);
        return power && ((n[i] == 0) || out_ready);
    endfunction

    task automatic cmp(string name, int inst, logic [159:0] act, logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h want %0h at %0t", name, inst, act, exp, $time);
        end
    endtask

    // Model update on the stage's updating (falling) edge.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                n[i] = 0;
                cnt[i] = 0;
            end else begin
                logic acc, pp;
                if (power && n[i] > 0 && !out_ready && cnt[i] < cmax[i]) cnt[i]++;
                if (flush) begin
                    n[i] = 0;
                end else if (power) begin
                    acc = in_valid && exp_ready(i);
                    pp  = (n[i] > 0) && out_ready;
                    if (pp) begin
                        qc[i][0] = qc[i][1];
                        qd[i][0] = qd[i][1];
                        n[i]--;
                    end
                    if (acc) begin
                        qc[i][n[i]] = in_ctrl;
                        qd[i][n[i]] = in_data;
                        n[i]++;
                    end
                end
            end
        end
    end

    // Per-cycle comparison, away from the falling edge.
    always @(posedge clk) begin
        #2;
        if (chk) begin
            for (int i = 0; i < 3; i++) begin
                cmp("out_valid", i, {159'd0, ov[i]}, {159'd0, (n[i] > 0)});
                cmp("out_ctrl", i, {152'd0, oc[i]}, {152'd0, (n[i] > 0) ? qc[i][0] : 8'h00});
                if (n[i] > 0) cmp("out_data", i, od[i], qd[i][0]);
                cmp("in_ready", i, {159'd0, ir[i]}, {159'd0, exp_ready(i)});
                cmp("stall_cnt", i, {144'd0, sc[i]}, 160'(cnt[i]));
            end
        end
    end

    task automatic step(input logic r, input logic f, input logic p,
                        input logic iv, input logic [7:0] c, input logic ordy);
        @(posedge clk);
        reset = r; flush = f; power = p; in_valid = iv; in_ctrl = c;
        in_data = {20{c}}; out_ready = ordy;
        #3;
    endtask

    initial begin
        logic [15:0] sc_before;
        logic [7:0]  pat;
        reset = 1'b1; flush = 1'b0; power = 1'b1; in_valid = 1'b0;
        in_ctrl = 8'h00; in_data = 160'd0; out_ready = 1'b0;
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        cmp("rst_out_valid", 0, {159'd0, ov0}, 160'd0);
        cmp("rst_out_ctrl", 0, {152'd0, oc0}, 160'd0);
        cmp("rst_out_data", 0, od0, 160'd0);
        cmp("rst_stall_cnt", 0, {144'd0, sc0}, 160'd0);
        cmp("rst_in_ready", 0, {159'd0, ir0}, 160'd1);

        // Single payload, one-edge latency.
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        cmp("lat_valid", 0, {159'd0, ov0}, 160'd1);
        cmp("lat_ctrl", 0, {152'd0, oc0}, 160'h5A);
        cmp("lat_stall", 0, {144'd0, sc0}, 160'd0);

        // Fill the skid buffer, then drain in order.
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'hB2, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        cmp("full_in_ready", 0, {159'd0, ir0}, 160'd0);
        cmp("full_head", 0, {152'd0, oc0}, 160'hA1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        cmp("full_stall", 0, {144'd0, sc0}, 160'd2);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        cmp("drain_a", 0, {152'd0, oc0}, 160'hA1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        cmp("drain_b", 0, {152'd0, oc0}, 160'hB2);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        cmp("drain_empty", 0, {159'd0, ov0}, 160'd0);

        // Flush from FULL with a colliding input.
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'hD4, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'hEE, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        cmp("flush_valid", 0, {159'd0, ov0}, 160'd0);
        cmp("flush_ctrl", 0, {152'd0, oc0}, 160'd0);
        cmp("flush_in_ready", 0, {159'd0, ir0}, 160'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);

        // Power gating in state ONE.
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h77, 1'b0);
        sc_before = sc0;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 8'h99, 1'b1);
            cmp("pwr_in_ready", 0, {159'd0, ir0}, 160'd0);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        cmp("pwr_hold_ctrl", 0, {152'd0, oc0}, 160'h77);
        cmp("pwr_hold_stall", 0, {144'd0, sc0}, {144'd0, sc_before});
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        cmp("pwr_popped", 0, {159'd0, ov0}, 160'd0);

        // Stall counter saturation on the 4-bit instance.
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h33, 1'b0);
        for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        cmp("sat_stall", 2, {156'd0, sc2}, 160'd15);

        // Reset while FULL: no output pulse afterwards.
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h44, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        cmp("rstfull_valid", 0, {159'd0, ov0}, 160'd0);
        cmp("rstfull_stall", 2, {156'd0, sc2}, 160'd0);

        // Continuous stream with toggling out_ready on the no-skid instance.
        pat = 8'b0110_1101;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, 8'h40 + 8'(k), pat[k]);
            if (ov1) cmp("noskid_ready", 1, {159'd0, ir1}, {159'd0, pat[k]});
        end
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
